spi: RTL and testbench



---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_ram.sv | 84 ++++++++
 rtl/spi.sv | 123 ++++++++++++
 tb/tb_spi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI-to-RAM access port.
//   - FSM state encodings (IDLE, WRITE, READ, DONE, READ_DATA)
//   - frame op codes carried in rx_data[9:8]
//   - FRAME_BITS: serial frame length (rw bit + 10 payload bits)
package spi_pkg;

    localparam int unsigned FRAME_BITS = 11;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE     = 3'd1;
    localparam logic [2:0] READ      = 3'd2;
    localparam logic [2:0] DONE      = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram.sv
// spi_ram: 256x8 single-port RAM with write/read address registers and op decode.
// Acts on each rx_valid_i pulse according to rx_data_i[9:8]:
//   00 latch write address, 01 write byte, 10 latch read address, 11 read byte.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   rx_valid_i          one-cycle strobe: rx_data_i holds a complete frame payload
//   rx_data_i[9:0]      op (9:8) and address/data byte (7:0)
//   tx_data_o[7:0]      registered read byte
//   tx_valid_o          one-cycle strobe: tx_data_o was just loaded
// Build option: SPI_READ_ORDER_EN -- when defined, a read-data op is ignored unless a
// read-address op has completed since reset or since the previous read-data op.
module spi_ram
    import spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_valid_i,
    input  logic [9:0] rx_data_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o
);

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic [1:0]           op;
    logic                 rd_ok;

    assign op = rx_data_i[9:8];

`ifdef SPI_READ_ORDER_EN
    logic rd_armed_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_armed_q <= 1'b0;
        end else if (rx_valid_i) begin
            if (op == OP_RD_ADDR) begin
                rd_armed_q <= 1'b1;
            end else if (op == OP_RD_DATA) begin
                rd_armed_q <= 1'b0;
            end
        end
    end

    assign rd_ok = rd_armed_q;
`else
    assign rd_ok = 1'b1;
`endif

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rx_valid_i && op == OP_WR_DATA) begin
            mem[wr_addr_q] <= rx_data_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
        end else begin
            tx_valid_o <= 1'b0;
            if (rx_valid_i) begin
                if (op == OP_WR_ADDR) begin
                    wr_addr_q <= rx_data_i[ADDR_SIZE-1:0];
                end
                if (op == OP_RD_ADDR) begin
                    rd_addr_q <= rx_data_i[ADDR_SIZE-1:0];
                end
                if (op == OP_RD_DATA && rd_ok) begin
                    tx_data_o  <= mem[rd_addr_q];
                    tx_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi.sv
// spi: SPI slave (mode-0 style, sampled on clk) fronting a 256x8 RAM.
// An 11-bit frame (rw, then rx_data[9:0] MSB first) is clocked in while SS_n is low.
// Read-data frames return the addressed byte on MISO, MSB first.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   MOSI    serial data in
//   SS_n    active-low slave select; high aborts any frame in progress
//   MISO    serial read data out; 0 whenever not shifting a read byte
// Build option: SPI_READ_ORDER_EN (implemented in spi_ram) gates read-data frames
// on a preceding read-address frame.
module spi
    import spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q;
    logic       rw_q;
    logic [9:0] shift_q;
    logic       pending_q;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    always_comb begin
        state_d = state_q;
        if (SS_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:        state_d = MOSI ? READ : WRITE;
                WRITE, READ: if (cnt_q == 4'd9) state_d = DONE;
                DONE:        if (rw_q && shift_q[9:8] == OP_RD_DATA) state_d = READ_DATA;
                READ_DATA:   state_d = READ_DATA;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rw_q      <= 1'b0;
            shift_q   <= 10'd0;
            pending_q <= 1'b0;
            rx_data   <= 10'd0;
            rx_valid  <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            state_q <= state_d;
            // The completed frame is released one cycle after its last bit, independent
            // of SS_n, so a master may deselect right after the final bit.
            pending_q <= 1'b0;
            rx_valid  <= pending_q && (shift_q[9] == rw_q);
            if (pending_q) begin
                rx_data <= shift_q;
            end

            if (SS_n) begin
                cnt_q <= 4'd0;
                MISO  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        rw_q  <= MOSI;
                        cnt_q <= 4'd0;
                        MISO  <= 1'b0;
                    end
                    WRITE, READ: begin
                        shift_q <= {shift_q[8:0], MOSI};
                        MISO    <= 1'b0;
                        if (cnt_q == 4'd9) begin
                            cnt_q     <= 4'd0;
                            pending_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    READ_DATA: begin
                        // cnt_q counts bits already driven; 8 means the byte is finished.
                        if (tx_valid) begin
                            MISO  <= tx_data[7];
                            cnt_q <= 4'd1;
                        end else if (cnt_q != 4'd0 && cnt_q < 4'd8) begin
                            MISO  <= tx_data[3'd7 - cnt_q[2:0]];
                            cnt_q <= cnt_q + 4'd1;
                        end else begin
                            MISO <= 1'b0;
                        end
                    end
                    default: begin
                        cnt_q <= 4'd0;
                        MISO  <= 1'b0;
                    end
                endcase
            end
        end
    end

    spi_ram #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) r1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid)
    );

endmodule

// File: tb/tb_spi.sv
// tb_spi: self-checking bench for spi. Inputs change on the falling edge; outputs are
// sampled on the falling edge. Expected read bytes are queued when a read-data frame is
// driven and popped when the byte has been collected from MISO.
module tb_spi;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic MOSI;
    logic SS_n;
    logic MISO;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_tx;

    always #5 clk = ~clk;

    spi #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8)
    ) DUT (
        .clk   (clk),
        .rst_n (rst_n),
        .MOSI  (MOSI),
        .SS_n  (SS_n),
        .MISO  (MISO)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic shift_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            SS_n = 1'b0;
            MOSI = frame[10-i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            SS_n = 1'b1;
            MOSI = 1'b0;
        end
    endtask

    task automatic send(input logic rw, input logic [1:0] op, input logic [7:0] d);
        shift_bits({rw, op, d}, 11);
        idle(3);
    endtask

    // Read-data frame with SS_n held low long enough to collect the whole byte.
    task automatic read_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        logic [7:0] e;
        exp_q.push_back(exp);
        shift_bits({1'b1, OP_RD_DATA, 8'h00}, 11);
        @(negedge clk);
        MOSI = 1'b0;
        check_eq({tag, "_miso_pre"}, 32'(MISO), 32'd0);
        @(negedge clk);
        check_eq({tag, "_tx_old"}, 32'(DUT.tx_data), 32'(model_tx));
        @(negedge clk);
        check_eq({tag, "_tx_new"}, 32'(DUT.tx_data), 32'(exp));
        model_tx = exp;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got[7-k] = MISO;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_miso_byte"}, 32'(got), 32'(e));
        @(negedge clk);
        check_eq({tag, "_miso_post"}, 32'(MISO), 32'd0);
        idle(2);
    endtask

    // Read-data frame with SS_n released right after the last bit.
    task automatic read_early(input string tag, input logic [7:0] exp);
        logic any_miso;
        shift_bits({1'b1, OP_RD_DATA, 8'h00}, 11);
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        any_miso = MISO;
        @(negedge clk);
        any_miso |= MISO;
        check_eq({tag, "_tx_old"}, 32'(DUT.tx_data), 32'(model_tx));
        @(negedge clk);
        any_miso |= MISO;
        check_eq({tag, "_tx_new"}, 32'(DUT.tx_data), 32'(exp));
        model_tx = exp;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            any_miso |= MISO;
        end
        check_eq({tag, "_miso_quiet"}, 32'(any_miso), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        model_tx = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_tx", 32'(DUT.tx_data), 32'd0);
        check_eq("rst_state", 32'(DUT.state_q), 32'(IDLE));
        rst_n = 1'b1;
        idle(2);

        // Neighbours first, then the target word.
        send(1'b0, OP_WR_ADDR, 8'hA4);
        send(1'b0, OP_WR_DATA, 8'h11);
        send(1'b0, OP_WR_ADDR, 8'hA6);
        send(1'b0, OP_WR_DATA, 8'h77);
        send(1'b0, OP_WR_ADDR, 8'hA5);
        send(1'b0, OP_WR_DATA, 8'h3C);
        check_eq("mem_a5", 32'(DUT.r1.mem[8'hA5]), 32'h3C);
        check_eq("mem_a4", 32'(DUT.r1.mem[8'hA4]), 32'h11);
        check_eq("mem_a6", 32'(DUT.r1.mem[8'hA6]), 32'h77);

        send(1'b1, OP_RD_ADDR, 8'hA5);
        read_byte("rd_a5", 8'h3C);

        send(1'b1, OP_RD_ADDR, 8'hA4);
        read_byte("rd_a4", 8'h11);
        send(1'b1, OP_RD_ADDR, 8'hA5);
        read_early("early_a5", 8'h3C);

        // Abort after 5 bits of a write-data frame (wr_addr is still 0xA5).
        shift_bits({1'b0, OP_WR_DATA, 8'hFF}, 5);
        idle(4);
        check_eq("abort_mem_a5", 32'(DUT.r1.mem[8'hA5]), 32'h3C);
        check_eq("abort_state", 32'(DUT.state_q), 32'(IDLE));
        send(1'b1, OP_RD_ADDR, 8'hA6);
        read_byte("after_abort", 8'h77);

        // 0x5A at 0x10, then frames whose rw bit disagrees with op[1].
        send(1'b0, OP_WR_ADDR, 8'h10);
        send(1'b0, OP_WR_DATA, 8'h5A);
        send(1'b1, OP_RD_ADDR, 8'h10);
        send(1'b0, OP_RD_DATA, 8'h10);
        check_eq("mismatch_rd_tx", 32'(DUT.tx_data), 32'(model_tx));
        send(1'b1, OP_WR_ADDR, 8'hA4);
        send(1'b0, OP_WR_DATA, 8'h5A);
        check_eq("mismatch_wr_a4", 32'(DUT.r1.mem[8'hA4]), 32'h11);
        check_eq("mem_10", 32'(DUT.r1.mem[8'h10]), 32'h5A);
        read_byte("rd_10", 8'h5A);

        // Reset during bit 6 of a read-address frame.
        shift_bits({1'b1, OP_RD_ADDR, 8'hA4}, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_miso", 32'(MISO), 32'd0);
        check_eq("midrst_tx", 32'(DUT.tx_data), 32'd0);
        check_eq("midrst_state", 32'(DUT.state_q), 32'(IDLE));
        check_eq("midrst_mem_a5", 32'(DUT.r1.mem[8'hA5]), 32'h3C);
        model_tx = 8'h00;
        @(negedge clk);
        SS_n  = 1'b1;
        rst_n = 1'b1;
        idle(2);
        send(1'b1, OP_RD_ADDR, 8'hA5);
        read_byte("post_rst_a5", 8'h3C);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
